retry_inorder_end: RTL and testbench
====================================

# retry_inorder_end

Receiving end of the retry protocol that restores issue order. It sits after `time_DMR_end`, in the same position as `retry_end`. Results without `needs_retry` are written into a reorder buffer indexed by ID. Results with `needs_retry` send their ID back to `retry_start`. Downstream receives data strictly in the ID order that `retry_start` issued, so retried operations cannot overtake or be overtaken.

## Interface
Parameters:
- `DataType`, default `logic`: payload type.
- `IDSize`, default `4`: ID width. The buffer depth is `2**IDSize`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `data_i`, in, `$bits(DataType)`: upstream payload.
- `id_i`, in, `IDSize`: upstream ID.
- `needs_retry_i`, in, 1: upstream result is faulty and must be reissued.
- `valid_i`, in, 1: upstream valid.
- `ready_o`, out, 1: upstream ready.
- `data_o`, out, `$bits(DataType)`: in-order payload.
- `valid_o`, out, 1: downstream valid.
- `ready_i`, in, 1: downstream ready.
- `retry_id_o`, out, `IDSize`: ID to reissue.
- `retry_valid_o`, out, 1: retry request valid.
- `retry_ready_i`, in, 1: `retry_start` accepts the retry request.

## Operation
- State:
  - `slot_data[2**IDSize]` of `DataType`.
  - `slot_vld[2**IDSize]`.
  - `head` pointer, `IDSize` bits, wraps modulo `2**IDSize`.
- Upstream contract:
  - `retry_start` issues IDs in increasing order modulo `2**IDSize`.
  - At most `2**IDSize` IDs are outstanding.
  - A retried ID keeps its original value.
- Retry path (combinational):
  - `retry_valid_o = valid_i & needs_retry_i`.
  - `retry_id_o = id_i`.
- Ready:
  - `ready_o = needs_retry_i ? retry_ready_i : ~slot_vld[id_i]`.
  - `slot_vld` in this term is the registered value; a slot freed this cycle becomes writable next cycle.
- Store: on `valid_i & ready_o & ~needs_retry_i`, `slot_data[id_i] <= data_i` and `slot_vld[id_i] <= 1`.
- Output:
  - `valid_o = slot_vld[head]`.
  - `data_o = slot_data[head]`.
  - On `valid_o & ready_i`: `slot_vld[head] <= 0` and `head <= head + 1`.
- Store and pop in the same cycle always target different slots, because a write requires the slot to be free and a pop requires it to be full. Both take effect.
- Protocol rules:
  - Once `valid_o` is asserted it stays high, with stable `data_o`, until accepted.
  - `retry_valid_o` follows upstream `valid_i`, so it obeys the upstream hold rules.
- No FSM beyond the pointer and occupancy bits.
- An arriving ID whose slot is occupied, which is a protocol violation, is back-pressured and never overwrites the slot.

## Timing
- Reset values:
  - `head = 0`, all `slot_vld = 0`.
  - `valid_o = 0`, `data_o = slot_data[0]` (reset to `'0`).
  - `retry_valid_o = 0` while `valid_i = 0`.
  - `ready_o` is driven combinationally.
- Latency, without bypass:
  - Input accepted at cycle `t` with `id_i == head`: `valid_o` rises at `t+1`.
  - Otherwise the result waits until every earlier ID has popped.
- Retry path: zero-cycle combinational; `ready_o` is the same-cycle `retry_ready_i`.
- Throughput: one store and one pop per cycle.
- Wrap-around: `head` goes from `2**IDSize-1` to `0` with no bubble.
- Full: all slots valid except `head`'s predecessor chain. Further non-retry inputs stall per slot.
- Empty: `valid_o = 0`.
- Reset mid-operation clears all slots immediately and asynchronously; buffered data is lost.

## Configuration
- Macro `RETRY_INORDER_BYPASS_EN`.
- Defined:
  - When `slot_vld[head] = 0`, `valid_i = 1`, `needs_retry_i = 0` and `id_i == head`, the input is forwarded combinationally: `valid_o = 1`, `data_o = data_i`.
  - If `ready_i = 1`, nothing is stored, `head` increments, and latency is 0.
  - If `ready_i = 0`, the input is stored as normal.
- Undefined: no combinational path from `valid_i` or `data_i` to `valid_o` or `data_o`; minimum latency is 1 cycle.

## Test plan
1. In order: IDs 0,1,2 with data `0xA`,`0xB`,`0xC`, `ready_i = 1` → `data_o` = A,B,C on consecutive cycles, each one cycle after input (0 cycles with bypass).
2. Out of order: ID 2 (`0xC`), then ID 0 (`0xA`), then ID 1 (`0xB`) → no output until ID 0 arrives, then A,B,C back-to-back; `head` = 3.
3. Retry: ID 1 arrives with `needs_retry_i = 1` and `retry_ready_i = 0` for 2 cycles, then 1 → `retry_valid_o` and `retry_id_o = 1` held 3 cycles; `ready_o` high only in the third cycle. ID 1 resent without retry → A,B,C in order.
4. Wrap-around with `IDSize = 2`: 10 sequential IDs 0..3,0..3,0,1 → 10 in-order outputs; `head` ends at 2.
5. Back-pressure: `ready_i = 0` while all 4 slots fill → `valid_o` and `data_o` stable on ID 0. A fifth ID 0 arrival gets `ready_o = 0`. On `ready_i = 1`, the fifth input is accepted one cycle after ID 0 pops.
6. Reset: async `rst_ni` low mid-stream with 3 slots valid → `valid_o = 0` immediately; after release the next ID 0 is output first.

Source files
------------

// File: rtl/retry_inorder_end.sv
// rtl/retry_inorder_end.sv - retry receiver with an ID-indexed reorder buffer that releases results in issue order.
// Optional macro RETRY_INORDER_BYPASS_EN forwards an in-order result straight to the output when its slot is empty.
module retry_inorder_end #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i
);

  localparam int unsigned Depth = 2 ** IDSize;

  DataType           slot_data [Depth];
  logic [Depth-1:0]  slot_vld;
  logic [IDSize-1:0] head;

  logic bypass;
  logic pop;
  logic store;

  assign retry_valid_o = valid_i & needs_retry_i;
  assign retry_id_o    = id_i;

  // Occupancy is the registered value: a slot popped this cycle is only writable next cycle.
  assign ready_o = needs_retry_i ? retry_ready_i : ~slot_vld[id_i];

`ifdef RETRY_INORDER_BYPASS_EN
  assign bypass = ~slot_vld[head] & valid_i & ~needs_retry_i & (id_i == head);
`else
  assign bypass = 1'b0;
`endif

  assign valid_o = slot_vld[head] | bypass;
  assign data_o  = bypass ? data_i : slot_data[head];

  assign pop = valid_o & ready_i;
  // A forwarded result that is consumed at once never occupies its slot.
  assign store = valid_i & ready_o & ~needs_retry_i & ~(bypass & ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head     <= '0;
      slot_vld <= '0;
      for (int i = 0; i < Depth; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        slot_vld[head] <= 1'b0;
        head           <= head + IDSize'(1);
      end
      // Store and pop never hit the same slot: one needs it free, the other full.
      if (store) begin
        slot_vld[id_i]  <= 1'b1;
        slot_data[id_i] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_retry_inorder_end.sv
// tb/tb_retry_inorder_end.sv - scoreboard bench for retry_inorder_end with a 4-entry buffer.
module tb_retry_inorder_end;

`ifdef RETRY_INORDER_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic [1:0] id_i;
  logic       needs_retry_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] retry_id_o;
  logic       retry_valid_o;
  logic       retry_ready_i;

  int checks;
  int failures;
  logic [7:0] sb[$];

  retry_inorder_end #(.DataType(logic [7:0]), .IDSize(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .id_i(id_i),
    .needs_retry_i(needs_retry_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .retry_id_o(retry_id_o), .retry_valid_o(retry_valid_o),
    .retry_ready_i(retry_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted output is checked against the head of the expected-order queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_order: data_o=%0h popped with nothing expected", data_o);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (data_o !== exp) begin
          failures++;
          $display("FAIL out_order: data_o=%0h required=%0h", data_o, exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i       = 1'b0;
    needs_retry_i = 1'b0;
    id_i          = '0;
    data_i        = '0;
  endtask

  task automatic set_in(input logic [1:0] id, input logic [7:0] d, input logic nr);
    valid_i       = 1'b1;
    id_i          = id;
    data_i        = d;
    needs_retry_i = nr;
  endtask

  task automatic apply_reset();
    idle_inputs();
    ready_i       = 1'b1;
    retry_ready_i = 1'b0;
    rst_n         = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: outstanding=%0d required=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: valid_o=%b data_o=%0h required valid 0 data 0", valid_o, data_o);
    end
    checks++;
    if (retry_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl: retry_valid_o=%b ready_o=%b required 0/1", retry_valid_o, ready_o);
    end
    checks++;
    if (dut.head !== 2'd0) begin
      failures++;
      $display("FAIL reset_head: head=%0d required=0", dut.head);
    end
    cyc();
  endtask

  task automatic test_in_order();
    logic [4:0] ev;
    ev = Byp ? 5'b00111 : 5'b01110;
    apply_reset();
    sb.push_back(8'h0A); sb.push_back(8'h0B); sb.push_back(8'h0C);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_in(2'(i), 8'h0A + 8'(i), 1'b0);
      else idle_inputs();
      @(negedge clk);
      checks++;
      if (valid_o !== ev[i]) begin
        failures++;
        $display("FAIL in_order_valid: cycle=%0d valid_o=%b required=%b", i, valid_o, ev[i]);
      end
      cyc();
    end
    check_drained("in_order");
  endtask

  task automatic test_out_of_order();
    logic [5:0] ev;
    logic [1:0] ids [3];
    logic [7:0] ds  [3];
    ids = '{2'd2, 2'd0, 2'd1};
    ds  = '{8'h0C, 8'h0A, 8'h0B};
    ev  = Byp ? 6'b001110 : 6'b011100;
    apply_reset();
    sb.push_back(8'h0A); sb.push_back(8'h0B); sb.push_back(8'h0C);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_in(ids[i], ds[i], 1'b0);
      else idle_inputs();
      @(negedge clk);
      checks++;
      if (valid_o !== ev[i]) begin
        failures++;
        $display("FAIL ooo_valid: cycle=%0d valid_o=%b required=%b", i, valid_o, ev[i]);
      end
      cyc();
    end
    check_drained("ooo");
    checks++;
    if (dut.head !== 2'd3) begin
      failures++;
      $display("FAIL ooo_head: head=%0d required=3", dut.head);
    end
  endtask

  task automatic test_retry();
    apply_reset();
    sb.push_back(8'h0A); sb.push_back(8'h0B); sb.push_back(8'h0C);
    set_in(2'd0, 8'h0A, 1'b0); cyc();
    set_in(2'd2, 8'h0C, 1'b0); cyc();
    for (int k = 0; k < 3; k++) begin
      set_in(2'd1, 8'hEE, 1'b1);
      retry_ready_i = (k == 2);
      @(negedge clk);
      checks++;
      if (retry_valid_o !== 1'b1 || retry_id_o !== 2'd1) begin
        failures++;
        $display("FAIL retry_req: cycle=%0d retry_valid_o=%b retry_id_o=%0d required 1/1", k, retry_valid_o, retry_id_o);
      end
      checks++;
      if (ready_o !== (k == 2)) begin
        failures++;
        $display("FAIL retry_ready: cycle=%0d ready_o=%b required=%b", k, ready_o, (k == 2));
      end
      checks++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL retry_hold: cycle=%0d valid_o=%b required=0", k, valid_o);
      end
      cyc();
    end
    retry_ready_i = 1'b0;
    set_in(2'd1, 8'h0B, 1'b0);
    @(negedge clk);
    checks++;
    if (retry_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL retry_clear: retry_valid_o=%b required=0", retry_valid_o);
    end
    cyc();
    idle_inputs();
    repeat (4) cyc();
    check_drained("retry");
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 10; i++) sb.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      set_in(2'(i % 4), 8'h10 + 8'(i), 1'b0);
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin
        failures++;
        $display("FAIL wrap_ready: input=%0d ready_o=%b required=1", i, ready_o);
      end
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();
    check_drained("wrap");
    checks++;
    if (dut.head !== 2'd2) begin
      failures++;
      $display("FAIL wrap_head: head=%0d required=2", dut.head);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) sb.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      set_in(2'(i), 8'h20 + 8'(i), 1'b0);
      cyc();
    end
    set_in(2'd0, 8'h24, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h20) begin
        failures++;
        $display("FAIL bp_stall: cycle=%0d ready_o=%b valid_o=%b data_o=%0h required 0/1/20", k, ready_o, valid_o, data_o);
      end
      cyc();
    end
    ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_pop_cycle: ready_o=%b required=0", ready_o);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept: ready_o=%b required=1", ready_o);
    end
    cyc();
    idle_inputs();
    repeat (6) cyc();
    check_drained("bp");
  endtask

  task automatic test_async_reset();
    apply_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(2'(i), 8'h50 + 8'(i), 1'b0);
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: valid_o=%b data_o=%0h required 0/0", valid_o, data_o);
    end
    cyc();
    rst_n   = 1'b1;
    ready_i = 1'b1;
    cyc();
    sb.push_back(8'h30); sb.push_back(8'h31);
    set_in(2'd1, 8'h31, 1'b0);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL async_slot_free: ready_o=%b required=1", ready_o);
    end
    cyc();
    set_in(2'd0, 8'h30, 1'b0);
    cyc();
    idle_inputs();
    repeat (4) cyc();
    check_drained("async");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    ready_i       = 1'b1;
    retry_ready_i = 1'b0;
    idle_inputs();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_retry();
    test_wrap();
    test_back_pressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
